// File: rtl/rr_arb_nto1_pkg.sv
// Shared crossbar definitions: index-width helper, payload slicing and reset constants
// used by the N-to-1 arbiter and the 1-to-M demux generator.
package rr_arb_nto1_pkg;

    localparam int PTR_RST    = 0;
    localparam int DEFAULT_PW = 4;

    // Index width for n sources; a single source still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // LSB position of source idx inside a flat {src[N-1], ..., src[0]} payload bus.
    function automatic int pld_lsb(input int idx, input int pw);
        return idx * pw;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest requester at or above ptr, else wrap to the
// lowest requester overall. Double-width mask / priority-encode form.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_vld,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_any
);

    logic [N-1:0]   w_mask;
    logic [2*N-1:0] w_dbl;
    int             w_pos;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i >= int'(i_ptr));
        end
        // Low half holds requesters at/after ptr, high half the wrapped copy.
        w_dbl = {i_vld, i_vld & w_mask};
        w_pos = 0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (w_dbl[j]) w_pos = j;
        end
        o_any     = |i_vld;
        o_gnt_idx = (w_pos >= N) ? IW'(w_pos - N) : IW'(w_pos);
        o_gnt     = o_any ? (N'(1) << o_gnt_idx) : '0;
    end

endmodule

// File: rtl/rr_arb_nto1.sv
// N-to-1 round-robin arbiter with a single-entry output register; one instance per
// crossbar destination column.
module rr_arb_nto1
    import rr_arb_nto1_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = DEFAULT_PW,
    parameter int IW = clog2_min1(N)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    i_vld_src,
    input  logic [N*PW-1:0] i_pld_src,
    output logic [N-1:0]    o_rdy_src,
    output logic            o_vld_dst,
    output logic [PW-1:0]   o_pld_dst,
    output logic [IW-1:0]   o_sel_dst,
    input  logic            i_rdy_dst
);

    logic          r_vld;
    logic [PW-1:0] r_pld;
    logic [IW-1:0] r_sel;
    logic [IW-1:0] r_ptr;

    logic [N-1:0]  w_gnt;
    logic [IW-1:0] w_idx;
    logic          w_any;
    logic          w_can_load;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .i_vld     (i_vld_src),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_idx),
        .o_any     (w_any)
    );

    // Refill is allowed in the same cycle the destination pops the held beat.
    assign w_can_load = !r_vld || i_rdy_dst;
    assign o_rdy_src  = (w_can_load && !i_rst) ? w_gnt : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= 1'b0;
            r_pld <= '0;
            r_sel <= '0;
            r_ptr <= IW'(PTR_RST);
        end else if (w_can_load) begin
            r_vld <= w_any;
            if (w_any) begin
                r_pld <= i_pld_src[pld_lsb(int'(w_idx), PW) +: PW];
                r_sel <= w_idx;
                r_ptr <= (w_idx == IW'(N-1)) ? '0 : w_idx + IW'(1);
            end
        end
    end

    assign o_vld_dst = r_vld;
    assign o_pld_dst = r_pld;
    assign o_sel_dst = r_sel;

endmodule

// File: tb/tb_rr_arb_nto1.sv
// Table-driven directed checks on a 2-source arbiter plus randomized checks of a
// 4-source arbiter against a cycle-level reference model.
module tb_rr_arb_nto1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 2-source instance
    logic       rst2;
    logic [1:0] vld2;
    logic [7:0] pld2;
    logic [1:0] rdy_src2;
    logic       vld_dst2;
    logic [3:0] pld_dst2;
    logic [0:0] sel_dst2;
    logic       rdy_dst2;

    rr_arb_nto1 #(.N(2), .PW(4), .IW(1)) u2 (
        .i_clk     (clk),
        .i_rst     (rst2),
        .i_vld_src (vld2),
        .i_pld_src (pld2),
        .o_rdy_src (rdy_src2),
        .o_vld_dst (vld_dst2),
        .o_pld_dst (pld_dst2),
        .o_sel_dst (sel_dst2),
        .i_rdy_dst (rdy_dst2)
    );

    // 4-source instance
    logic        rst4;
    logic [3:0]  vld4;
    logic [31:0] pld4;
    logic [3:0]  rdy_src4;
    logic        vld_dst4;
    logic [7:0]  pld_dst4;
    logic [1:0]  sel_dst4;
    logic        rdy_dst4;

    rr_arb_nto1 #(.N(4), .PW(8), .IW(2)) u4 (
        .i_clk     (clk),
        .i_rst     (rst4),
        .i_vld_src (vld4),
        .i_pld_src (pld4),
        .o_rdy_src (rdy_src4),
        .o_vld_dst (vld_dst4),
        .o_pld_dst (pld_dst4),
        .o_sel_dst (sel_dst4),
        .i_rdy_dst (rdy_dst4)
    );

    typedef struct {
        logic       rst;
        logic [1:0] vld;
        logic [7:0] pld;
        logic       rdy;
        logic [1:0] e_rdy;
        logic       e_vld;
        logic [3:0] e_pld;
        logic       e_sel;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state for the 4-source instance
    int       m_vld, m_pld, m_sel, m_ptr;
    int       win;
    bit       can;
    bit [3:0] e_rdy;

    initial begin
        rst2 = 1'b1; vld2 = 2'b11; pld2 = 8'h21; rdy_dst2 = 1'b1;
        rst4 = 1'b1; vld4 = '0;    pld4 = '0;    rdy_dst4 = 1'b0;
        @(posedge clk); #1;

        // rst vld pld rdy | rdy_src vld pld sel  (outputs observed before the edge)
        tbl.push_back('{1'b1, 2'b11, 8'h21, 1'b1, 2'b00, 1'b0, 4'h0, 1'b0}); // reset hold
        tbl.push_back('{1'b1, 2'b11, 8'h21, 1'b1, 2'b00, 1'b0, 4'h0, 1'b0});
        tbl.push_back('{1'b0, 2'b11, 8'h21, 1'b1, 2'b01, 1'b0, 4'h0, 1'b0}); // first after release
        tbl.push_back('{1'b0, 2'b10, 8'hA0, 1'b1, 2'b10, 1'b1, 4'h1, 1'b0}); // single source 1
        tbl.push_back('{1'b0, 2'b00, 8'hA0, 1'b1, 2'b00, 1'b1, 4'hA, 1'b1}); // drain
        tbl.push_back('{1'b0, 2'b00, 8'hA0, 1'b1, 2'b00, 1'b0, 4'hA, 1'b1}); // payload held
        tbl.push_back('{1'b0, 2'b11, 8'h21, 1'b1, 2'b01, 1'b0, 4'hA, 1'b1}); // round-robin
        tbl.push_back('{1'b0, 2'b11, 8'h21, 1'b1, 2'b10, 1'b1, 4'h1, 1'b0});
        tbl.push_back('{1'b0, 2'b11, 8'h21, 1'b1, 2'b01, 1'b1, 4'h2, 1'b1});
        tbl.push_back('{1'b0, 2'b11, 8'h21, 1'b1, 2'b10, 1'b1, 4'h1, 1'b0});
        tbl.push_back('{1'b0, 2'b11, 8'h21, 1'b1, 2'b01, 1'b1, 4'h2, 1'b1});
        tbl.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b00, 1'b1, 4'h1, 1'b0}); // backpressure
        tbl.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b00, 1'b1, 4'h1, 1'b0});
        tbl.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b00, 1'b1, 4'h1, 1'b0});
        tbl.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b00, 1'b1, 4'h1, 1'b0});
        tbl.push_back('{1'b0, 2'b11, 8'h21, 1'b1, 2'b10, 1'b1, 4'h1, 1'b0}); // release: ptr held at 1
        tbl.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b00, 1'b1, 4'h2, 1'b1}); // stall, FULL
        tbl.push_back('{1'b1, 2'b11, 8'h21, 1'b0, 2'b00, 1'b1, 4'h2, 1'b1}); // mid-stall reset
        tbl.push_back('{1'b0, 2'b11, 8'h21, 1'b0, 2'b01, 1'b0, 4'h0, 1'b0}); // restart at source 0
        tbl.push_back('{1'b0, 2'b00, 8'h21, 1'b1, 2'b00, 1'b1, 4'h1, 1'b0});
        tbl.push_back('{1'b0, 2'b00, 8'h21, 1'b0, 2'b00, 1'b0, 4'h1, 1'b0});

        foreach (tbl[k]) begin
            rst2 = tbl[k].rst; vld2 = tbl[k].vld; pld2 = tbl[k].pld; rdy_dst2 = tbl[k].rdy;
            #3;
            chk($sformatf("v%0d rdy_src", k), 32'(rdy_src2), 32'(tbl[k].e_rdy));
            chk($sformatf("v%0d vld_dst", k), 32'(vld_dst2), 32'(tbl[k].e_vld));
            chk($sformatf("v%0d pld_dst", k), 32'(pld_dst2), 32'(tbl[k].e_pld));
            chk($sformatf("v%0d sel_dst", k), 32'(sel_dst2), 32'(tbl[k].e_sel));
            @(posedge clk); #1;
        end

        // Randomized run on the 4-source arbiter
        m_vld = 0; m_pld = 0; m_sel = 0; m_ptr = 0;
        for (int c = 0; c < 3000; c++) begin
            rst4     = (c == 0) || ($urandom_range(0, 99) == 0);
            vld4     = 4'($urandom_range(0, 15));
            pld4     = $urandom;
            rdy_dst4 = ($urandom_range(0, 3) != 0);
            #3;
            can = (m_vld == 0) || rdy_dst4;
            win = -1;
            if (can && !rst4) begin
                for (int k = 0; k < 4; k++) begin
                    if (win < 0 && vld4[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
                end
            end
            e_rdy = (win >= 0) ? 4'(1 << win) : 4'h0;
            if (c > 0) begin
                chk("rnd rdy_src", 32'(rdy_src4), 32'(e_rdy));
                chk("rnd vld_dst", 32'(vld_dst4), 32'(m_vld));
                chk("rnd pld_dst", 32'(pld_dst4), 32'(m_pld));
                chk("rnd sel_dst", 32'(sel_dst4), 32'(m_sel));
            end
            if (rst4) begin
                m_vld = 0; m_pld = 0; m_sel = 0; m_ptr = 0;
            end else if (can) begin
                if (win >= 0) begin
                    m_vld = 1;
                    m_pld = int'(pld4[win*8 +: 8]);
                    m_sel = win;
                    m_ptr = (win + 1) % 4;
                end else begin
                    m_vld = 0;
                end
            end
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
